// File: rtl/lcd_request_arbiter.sv
// Two-requester arbiter driving a 4-bit HD44780-style LCD write bus.
// Define LCD_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed A priority.
module lcd_request_arbiter #(
  parameter int E_PULSE_CYCLES    = 25,
  parameter int SETUP_CYCLES      = 4,
  parameter int NIBBLE_GAP_CYCLES = 100,
  parameter int CMD_WAIT_CYCLES   = 4000,
  parameter int CLEAR_WAIT_CYCLES = 164000
) (
  input  logic       Clock_100MHz,
  input  logic       Clear,
  input  logic       Req_A,
  input  logic [7:0] Data_A,
  input  logic       RS_A,
  output logic       Ack_A,
  input  logic       Req_B,
  input  logic [7:0] Data_B,
  input  logic       RS_B,
  output logic       Ack_B,
  output logic       Busy,
  output logic [3:0] LCD_DB,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam int M1 = (E_PULSE_CYCLES > SETUP_CYCLES)
                    ? E_PULSE_CYCLES : SETUP_CYCLES;
  localparam int M2 = (NIBBLE_GAP_CYCLES > M1)
                    ? NIBBLE_GAP_CYCLES : M1;
  localparam int M3 = (CMD_WAIT_CYCLES > M2)
                    ? CMD_WAIT_CYCLES : M2;
  localparam int MAXC = (CLEAR_WAIT_CYCLES > M3)
                      ? CLEAR_WAIT_CYCLES : M3;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] E_L     = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_L   = CW'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CMD_L   = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_L   = CW'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HI_SETUP, ST_HI_E, ST_GAP,
    ST_LO_SETUP, ST_LO_E, ST_WAIT, ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          selb_q, selb_d;
  logic          e_q, e_d;
  logic          busy_q, busy_d;
  logic          acka_q, acka_d;
  logic          ackb_q, ackb_d;
  logic          rso_q, rso_d;
  logic [3:0]    db_q, db_d;
  logic          grant_a;
  logic [CW-1:0] wait_l;

`ifdef LCD_ARB_ROUND_ROBIN_EN
  logic last_a_q, last_a_d;

  assign grant_a = Req_A & ~(Req_B & last_a_q);

  always_comb begin
    last_a_d = last_a_q;
    if (state_q == ST_IDLE && (Req_A | Req_B))
      last_a_d = grant_a;
  end

  // Reset value 0 means A was not served last, so A wins the first tie
  always_ff @(posedge Clock_100MHz or posedge Clear) begin
    if (Clear) last_a_q <= 1'b0;
    else       last_a_q <= last_a_d;
  end
`else
  assign grant_a = Req_A;
`endif

  // Clear and return-home commands need the long execution wait
  assign wait_l = (!rs_q && (data_q == 8'h01 || data_q == 8'h02))
                ? CLR_L : CMD_L;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    data_d  = data_q;
    rs_d    = rs_q;
    selb_d  = selb_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (Req_A | Req_B) begin
          state_d = ST_HI_SETUP;
          selb_d  = ~grant_a;
          data_d  = grant_a ? Data_A : Data_B;
          rs_d    = grant_a ? RS_A : RS_B;
        end
      end
      ST_HI_SETUP:
        if (cnt_q == SETUP_L) begin
          state_d = ST_HI_E;
          cnt_d   = '0;
        end
      ST_HI_E:
        if (cnt_q == E_L) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      ST_GAP:
        if (cnt_q == GAP_L) begin
          state_d = ST_LO_SETUP;
          cnt_d   = '0;
        end
      ST_LO_SETUP:
        if (cnt_q == SETUP_L) begin
          state_d = ST_LO_E;
          cnt_d   = '0;
        end
      ST_LO_E:
        if (cnt_q == E_L) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      ST_WAIT:
        if (cnt_q == wait_l) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus outputs are decoded from the next state and registered
  always_comb begin
    e_d    = (state_d == ST_HI_E) || (state_d == ST_LO_E);
    busy_d = (state_d != ST_IDLE);
    acka_d = (state_d == ST_DONE) && !selb_d;
    ackb_d = (state_d == ST_DONE) && selb_d;
    rso_d  = (state_d == ST_IDLE) ? rso_q : rs_d;
    unique case (state_d)
      ST_IDLE:     db_d = db_q;
      ST_HI_SETUP,
      ST_HI_E,
      ST_GAP:      db_d = data_d[7:4];
      default:     db_d = data_d[3:0];
    endcase
  end

  always_ff @(posedge Clock_100MHz or posedge Clear) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      selb_q  <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      acka_q  <= 1'b0;
      ackb_q  <= 1'b0;
      rso_q   <= 1'b0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      selb_q  <= selb_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      acka_q  <= acka_d;
      ackb_q  <= ackb_d;
      rso_q   <= rso_d;
      db_q    <= db_d;
    end
  end

  assign LCD_E  = e_q;
  assign LCD_DB = db_q;
  assign LCD_RS = rso_q;
  assign LCD_RW = 1'b0;
  assign Busy   = busy_q;
  assign Ack_A  = acka_q;
  assign Ack_B  = ackb_q;

endmodule

// File: tb/tb_lcd_request_arbiter.sv
// Randomized bench for lcd_request_arbiter against a timeline reference model.
// Honours LCD_ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_lcd_request_arbiter;

  localparam int S  = 2;
  localparam int E  = 3;
  localparam int G  = 5;
  localparam int CW = 12;
  localparam int CL = 40;
`ifdef LCD_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Clear;
  logic       Req_A, RS_A, Req_B, RS_B;
  logic [7:0] Data_A, Data_B;
  logic       Ack_A, Ack_B, Busy, LCD_E, LCD_RS, LCD_RW;
  logic [3:0] LCD_DB;

  always #5 clk = ~clk;

  lcd_request_arbiter #(
    .E_PULSE_CYCLES(E),
    .SETUP_CYCLES(S),
    .NIBBLE_GAP_CYCLES(G),
    .CMD_WAIT_CYCLES(CW),
    .CLEAR_WAIT_CYCLES(CL)
  ) dut (
    .Clock_100MHz(clk),
    .Clear(Clear),
    .Req_A(Req_A),
    .Data_A(Data_A),
    .RS_A(RS_A),
    .Ack_A(Ack_A),
    .Req_B(Req_B),
    .Data_B(Data_B),
    .RS_B(RS_B),
    .Ack_B(Ack_B),
    .Busy(Busy),
    .LCD_DB(LCD_DB),
    .LCD_E(LCD_E),
    .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pending requests per requester, {rs, data}
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  bit         fly;
  int         k;
  int         L;
  bit         win_b;
  logic [7:0] mbyte;
  logic       mrs;
  bit         last_was_a;
  int         cyc;
  int         t_grant, t_ack;
  int         erise[$];
  bit         winlog[$];
  logic       e_prev;
  bit         gen;
  int         scr;

  function automatic int lat(input logic [7:0] b, input logic rs);
    return 2*S + 2*E + G
         + ((!rs && (b == 8'h01 || b == 8'h02)) ? CL : CW);
  endfunction

  function automatic logic [8:0] rnd_item();
    logic [8:0] it;
    it = 9'($urandom);
    if ($urandom_range(0, 3) == 0)
      it = {1'b0, 7'h0, 1'b1} + 9'($urandom_range(0, 1));
    return it;
  endfunction

  // Expected {Busy,Ack_A,Ack_B,E,RS,DB,RW} from elapsed cycles since grant
  function automatic logic [9:0] expv();
    int p1, p2, p3, p4;
    logic [3:0] db;
    logic e, ack;
    p1 = S + E;
    p2 = p1 + G;
    p3 = p2 + S;
    p4 = p3 + E;
    if (!fly) return 10'b0;
    db  = (k < p2) ? mbyte[7:4] : mbyte[3:0];
    e   = (k >= S && k < p1) || (k >= p3 && k < p4);
    ack = (k == L);
    return {1'b1, ack && !win_b, ack && win_b, e, mrs, db, 1'b0};
  endfunction

  task automatic step();
    logic [9:0] obs;
    logic [8:0] fa, fb;
    @(negedge clk);
    cyc++;
    obs = {Busy, Ack_A, Ack_B, LCD_E,
           fly ? LCD_RS : 1'b0, fly ? LCD_DB : 4'h0, LCD_RW};
    chk("cycle", 32'(obs), 32'(expv()));
    if (LCD_E && !e_prev) erise.push_back(cyc);
    e_prev = LCD_E;
    if (Ack_A || Ack_B) begin
      t_ack = cyc;
      winlog.push_back(Ack_B);
    end
    if (gen && qa.size() < 2 && $urandom_range(0, 7) == 0)
      qa.push_back(rnd_item());
    if (gen && qb.size() < 2 && $urandom_range(0, 7) == 0)
      qb.push_back(rnd_item());
    fa = (qa.size() > 0) ? qa[0] : 9'($urandom);
    fb = (qb.size() > 0) ? qb[0] : 9'($urandom);
    Req_A = qa.size() > 0;
    Req_B = qb.size() > 0;
    {RS_A, Data_A} = fa;
    {RS_B, Data_B} = fb;
    if (fly && scr == 1) begin
      if (!win_b) {Req_A, RS_A, Data_A} = 10'($urandom);
      else        {Req_B, RS_B, Data_B} = 10'($urandom);
    end else if (fly && scr == 2) begin
      if (!win_b) {Req_A, RS_A, Data_A} = {1'b0, 1'b0, 8'hFF};
      else        {Req_B, RS_B, Data_B} = {1'b0, 1'b0, 8'hFF};
    end
    if (fly) begin
      if (k == L) begin
        fly = 0;
        if (win_b) void'(qb.pop_front());
        else       void'(qa.pop_front());
      end else k++;
    end else if (Req_A || Req_B) begin
      win_b = Req_B && (!Req_A || (RR && last_was_a));
      {mrs, mbyte} = win_b ? {RS_B, Data_B} : {RS_A, Data_A};
      last_was_a = !win_b;
      fly = 1;
      k = 0;
      L = lat(mbyte, mrs);
      t_grant = cyc + 1;
    end
  endtask

  // Called just after a rising edge; releases before the next falling edge
  task automatic clear_now();
    #1 Clear = 1'b1;
    #1;
    chk("rst_out", 32'({Busy, Ack_A, Ack_B, LCD_E, LCD_RS, LCD_DB, LCD_RW}),
        32'h0);
    fly = 0;
    k = 0;
    last_was_a = 0;
    #1 Clear = 1'b0;
  endtask

  task automatic run_until(input int n, input int bound);
    int i = 0;
    while (winlog.size() < n && i < bound) begin
      step();
      i++;
    end
    chk("ack_timeout", 32'(winlog.size() >= n), 32'd1);
  endtask

  task automatic drain(input int bound);
    int i = 0;
    while ((fly || qa.size() > 0 || qb.size() > 0) && i < bound) begin
      step();
      i++;
    end
    chk("drain_timeout", 32'(fly || qa.size() > 0 || qb.size() > 0), 32'd0);
  endtask

  initial begin
    bit rr_exp [4];
    int guard;
    Clear = 1'b1;
    Req_A = 0; Req_B = 0; RS_A = 0; RS_B = 0;
    Data_A = 0; Data_B = 0;
    fly = 0; k = 0; L = 0; last_was_a = 0; win_b = 0;
    mbyte = 0; mrs = 0; cyc = 0; e_prev = 0;
    gen = 0; scr = 0; t_grant = 0; t_ack = 0;
    #23;
    chk("reset", 32'({Busy, Ack_A, Ack_B, LCD_E, LCD_RS, LCD_DB, LCD_RW}),
        32'h0);
    #1 Clear = 1'b0;

    // Ordinary data byte from A
    erise.delete(); winlog.delete();
    qa.push_back({1'b1, 8'h48});
    run_until(1, 200);
    chk("a48_who", 32'(winlog.size() > 0 ? winlog[0] : 1'b1), 32'd0);
    chk("a48_lat", 32'(t_ack - t_grant), 32'(2*S + 2*E + G + CW));
    chk("a48_epulses", 32'(erise.size()), 32'd2);
    if (erise.size() == 2)
      chk("a48_espace", 32'(erise[1] - erise[0]), 32'(E + G + S));
    drain(50);

    // Clear-display command from B takes the long wait
    winlog.delete();
    qb.push_back({1'b0, 8'h01});
    run_until(1, 300);
    chk("b01_who", 32'(winlog.size() > 0 ? winlog[0] : 1'b0), 32'd1);
    chk("b01_lat", 32'(t_ack - t_grant), 32'(2*S + 2*E + G + CL));
    drain(50);

    // Both requesters contend for four transfers after a reset
    @(posedge clk);
    clear_now();
    winlog.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back({1'b1, 8'($urandom)});
      qb.push_back({1'b1, 8'($urandom)});
    end
    rr_exp = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    run_until(4, 600);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order%0d", i),
          32'(winlog.size() > i ? winlog[i] : ~rr_exp[i]), 32'(rr_exp[i]));
    drain(600);

    // Requester drops Req and garbles its byte mid-transfer
    winlog.delete();
    scr = 2;
    qa.push_back({1'b1, 8'h5A});
    run_until(1, 200);
    chk("drop_ack", 32'(winlog.size() > 0 ? winlog[0] : 1'b1), 32'd0);
    scr = 0;
    drain(50);

    // Reset during the high-nibble enable pulse, request still held
    winlog.delete();
    qa.push_back({1'b1, 8'h33});
    guard = 0;
    while (!(fly && k == S + 1) && guard < 50) begin
      step();
      guard++;
    end
    @(posedge clk);
    #1;
    chk("e_before_clr", 32'(LCD_E), 32'd1);
    clear_now();
    chk("no_ack_abort", 32'(winlog.size()), 32'd0);
    run_until(1, 200);
    chk("restart_lat", 32'(t_ack - t_grant), 32'(2*S + 2*E + G + CW));
    drain(50);

    // Random traffic with occasional resets
    gen = 1;
    scr = 1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 999) == 0) begin
        @(posedge clk);
        clear_now();
      end
    end
    gen = 0;
    drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
